target_generator: RTL

Upstream stage of switch_handler. It runs the game session: it picks a pseudo-random one-hot target switch, holds it for a shrinking time window, and retires it on a hit or a timeout. It also counts down the game clock and drives curr_target and game_over into switch_handler. It consumes target_hit back from switch_handler to advance to the next target and to speed up.

---
 rtl/target_generator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/target_generator.sv
// Game-session sequencer: presents pseudo-random one-hot targets with a shrinking
// hit window, retires them on hit or timeout, and counts down the session clock.
module target_generator #(
  parameter int unsigned N_SW        = 18,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned GAME_SEC    = 30,
  parameter int unsigned WIN_MS_INIT = 1500,
  parameter int unsigned WIN_MS_MIN  = 400,
  parameter int unsigned WIN_MS_STEP = 100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            target_hit,
  output logic [N_SW-1:0] curr_target,
  output logic            game_over,
  output logic [7:0]      time_left,
  output logic            target_timeout,
  output logic            new_target,
  output logic [15:0]     win_ms
);

  localparam int unsigned TICK_CYC = CLK_HZ / 1000;
  localparam int unsigned DIV_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYC - 1);
  localparam logic [5:0]  IDX_NONE = 6'(N_SW);
  localparam logic [15:0] WIN_INIT = 16'(WIN_MS_INIT);
  localparam logic [15:0] WIN_MIN  = 16'(WIN_MS_MIN);
  localparam logic [15:0] WIN_STEP = 16'(WIN_MS_STEP);

  typedef enum logic [1:0] {StIdle, StPick, StActive, StOver} state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [5:0]        prev_idx_q, prev_idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [9:0]        ms_cnt_q, ms_cnt_d;
  logic [15:0]       win_cnt_q, win_cnt_d;
  logic [N_SW-1:0]   curr_target_q, curr_target_d;
  logic              game_over_q, game_over_d;
  logic [7:0]        time_left_q, time_left_d;
  logic              target_timeout_q, target_timeout_d;
  logic              new_target_q, new_target_d;
  logic [15:0]       win_ms_q, win_ms_d;

  logic        ms_tick;
  logic        sec_done;
  logic        sess_end;
  logic        win_expire;
  logic [5:0]  cand_idx;
  logic        cand_ok;
  logic [15:0] win_dec;
  logic [15:0] lfsr_next;

  assign ms_tick    = (div_q == DIV_LAST);
  assign sec_done   = ms_tick && (ms_cnt_q == 10'd999);
  assign sess_end   = sec_done && (time_left_q == 8'd1);
  assign win_expire = ms_tick && (win_cnt_q == win_ms_q - 16'd1);
  assign cand_idx   = {1'b0, lfsr_q[4:0]};
  assign cand_ok    = (cand_idx < IDX_NONE) && (cand_idx != prev_idx_q);
  assign win_dec    = (win_ms_q >= WIN_MIN + WIN_STEP) ? win_ms_q - WIN_STEP : WIN_MIN;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11; a nonzero seed never reaches zero.
  assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d          = state_q;
    lfsr_d           = lfsr_next;
    prev_idx_d       = prev_idx_q;
    div_d            = ms_tick ? '0 : div_q + DIV_W'(1);
    ms_cnt_d         = ms_cnt_q;
    win_cnt_d        = win_cnt_q;
    curr_target_d    = curr_target_q;
    game_over_d      = game_over_q;
    time_left_d      = time_left_q;
    target_timeout_d = 1'b0;
    new_target_d     = 1'b0;
    win_ms_d         = win_ms_q;

    // Session clock runs only while a game is in progress.
    if ((state_q == StPick || state_q == StActive) && ms_tick) begin
      ms_cnt_d = sec_done ? 10'd0 : ms_cnt_q + 10'd1;
      if (sec_done) begin
        time_left_d = time_left_q - 8'd1;
      end
    end

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d       = StPick;
          time_left_d   = 8'(GAME_SEC);
          win_ms_d      = WIN_INIT;
          div_d         = '0;
          ms_cnt_d      = '0;
          prev_idx_d    = IDX_NONE;
          game_over_d   = 1'b0;
          curr_target_d = '0;
        end
      end
      StPick: begin
        if (sess_end) begin
          state_d     = StOver;
          game_over_d = 1'b1;
        end else if (cand_ok) begin
          state_d       = StActive;
          curr_target_d = N_SW'(1) << cand_idx[4:0];
          prev_idx_d    = cand_idx;
          win_cnt_d     = '0;
          new_target_d  = 1'b1;
        end
      end
      StActive: begin
        if (ms_tick) begin
          win_cnt_d = win_cnt_q + 16'd1;
        end
        // Expiry beats hit beats window timeout.
        if (sess_end) begin
          state_d       = StOver;
          game_over_d   = 1'b1;
          curr_target_d = '0;
        end else if (target_hit) begin
          state_d       = StPick;
          win_ms_d      = win_dec;
          curr_target_d = '0;
        end else if (win_expire) begin
          state_d          = StPick;
          target_timeout_d = 1'b1;
          curr_target_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      lfsr_q           <= LFSR_SEED;
      prev_idx_q       <= '0;
      div_q            <= '0;
      ms_cnt_q         <= '0;
      win_cnt_q        <= '0;
      curr_target_q    <= '0;
      game_over_q      <= 1'b1;
      time_left_q      <= 8'(GAME_SEC);
      target_timeout_q <= 1'b0;
      new_target_q     <= 1'b0;
      win_ms_q         <= WIN_INIT;
    end else begin
      state_q          <= state_d;
      lfsr_q           <= lfsr_d;
      prev_idx_q       <= prev_idx_d;
      div_q            <= div_d;
      ms_cnt_q         <= ms_cnt_d;
      win_cnt_q        <= win_cnt_d;
      curr_target_q    <= curr_target_d;
      game_over_q      <= game_over_d;
      time_left_q      <= time_left_d;
      target_timeout_q <= target_timeout_d;
      new_target_q     <= new_target_d;
      win_ms_q         <= win_ms_d;
    end
  end

  assign curr_target    = curr_target_q;
  assign game_over      = game_over_q;
  assign time_left      = time_left_q;
  assign target_timeout = target_timeout_q;
  assign new_target     = new_target_q;
  assign win_ms         = win_ms_q;

endmodule
